host_rx_packet_assembler: RTL
=============================

// Module: host_rx_packet_assembler
// PURPOSE
//   Upstream framing stage for host_specific_top_rx_from_host. Receives the host byte stream.
//   Each frame is a length byte followed by N payload bytes. The block assembles the payload into
//   the 1024-bit command word, pulses send_packet, and holds the word stable until the downstream
//   stage signals done. Malformed and stalled frames are dropped and flagged.
// PARAMETERS
//   DATA_WIDTH      1024  width of packet_data; must equal downstream input_data width
//   MAX_BYTES       128   max payload bytes per frame (DATA_WIDTH/8, <=255)
//   TIMEOUT_CYCLES  1000  max idle clocks between payload bytes inside a frame
//   TIMEOUT_WIDTH   16    width of inter-byte timeout counter
// PORTS
//   clk             in   1           system clock, rising edge
//   reset           in   1           asynchronous, active-low reset
//   rx_byte         in   8           incoming host byte
//   rx_valid        in   1           rx_byte valid; byte accepted when rx_valid && rx_ready
//   rx_ready        out  1           block can accept a byte this cycle
//   packet_data     out  DATA_WIDTH  assembled command; first payload byte in [7:0]
//   send_packet     out  1           one-cycle strobe: packet_data is valid, start processing
//   done            in   1           downstream completion (level or pulse)
//   frame_error     out  1           one-cycle pulse: bad length or inter-byte timeout
//   busy            out  1           high whenever state != IDLE
// BEHAVIOUR
//   Reset (reset low, async): state=IDLE, packet_data=0, send_packet=0, frame_error=0,
//     busy=0, byte count=0, timeout count=0, done_q=0. rx_ready=1 once reset deasserts.
//   done_q is done registered every cycle. done_rise = done && !done_q.
//   IDLE: rx_ready=1. On an accepted byte L:
//     L==0 or L>MAX_BYTES -> frame_error=1 next cycle, stay IDLE, packet_data unchanged.
//     Otherwise latch len=L, clear packet_data to 0, count=0, timeout=0, go to RECV.
//   RECV: rx_ready=1. An accepted byte is written to packet_data[8*count +: 8], count++,
//     and the timeout counter clears.
//     When the accepted byte is the len-th byte, go to SEND.
//     With no byte accepted, timeout++. When timeout reaches TIMEOUT_CYCLES: frame_error pulse,
//     packet_data cleared to 0, go to IDLE.
//   SEND: send_packet=1 for exactly this one cycle, rx_ready=0, go to WAIT_DONE.
//   WAIT_DONE: rx_ready=0, packet_data held stable. On done_rise go to IDLE.
//     A done level already high on entry is ignored; only a fresh rising edge completes.
//     Any done edge seen outside WAIT_DONE is ignored.
//   Latency: last payload byte accepted in cycle t -> send_packet high in cycle t+1.
//     Earliest done_rise is sampled in t+2. Next length byte can be accepted the cycle after.
//   Unused upper bytes of packet_data are always 0. No bytes are dropped silently while
//     rx_ready=1, and no byte is accepted while rx_ready=0.
//   frame_error and send_packet are never high in the same cycle.
//   Reset mid-frame discards all partial data. No done timeout; the block waits indefinitely.
// TESTING
//   1 Len 9, bytes 01,FF x6,01,01 -> send_packet 1 cycle after last byte;
//     packet_data=72'h0101FFFFFFFFFFFF01 zero-extended; rx_ready=0 until done rises.
//   2 Hold done high, then len 7, bytes 03,27,FF,27,FF,27,FF -> packet_data=56'hFF27FF27FF2703;
//     stays WAIT_DONE until done falls and rises again.
//   3 Len 0, then len 200 -> two frame_error pulses, no send_packet, busy stays 0.
//   4 Len 9, 4 bytes, then idle TIMEOUT_CYCLES -> frame_error, IDLE, packet_data=0.
//     A following len 7 frame (56'hFF27FF27FF2705) is assembled correctly.
//   5 Len 128, bytes 0..127 with rx_valid toggling -> packet_data byte k == k, one send_packet.
//   6 Reset low during RECV (after 3 of 9 bytes) -> all outputs 0 immediately;
//     next full frame from test 1 is assembled correctly.

Source files
------------

// File: rtl/host_rx_packet_assembler.sv
// -----------------------------------------------------------------------------
// host_rx_packet_assembler
//   Framing stage in front of host_specific_top_rx_from_host. The host sends
//   frames made of one length byte followed by that many payload bytes. The
//   payload is packed little-endian into packet_data (first byte in [7:0]).
//   The block then pulses send_packet and holds the word stable until the
//   downstream stage raises done. Frames with a bad length, or frames that go
//   quiet for too long between payload bytes, are dropped and flagged with a
//   one-cycle frame_error pulse.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-low reset
//   rx_byte      in   incoming host byte
//   rx_valid     in   rx_byte valid; accepted when rx_valid && rx_ready
//   rx_ready     out  block can accept a byte this cycle
//   packet_data  out  assembled command word, unused upper bytes are zero
//   send_packet  out  one-cycle strobe: packet_data is valid
//   done         in   downstream completion (level or pulse; rising edge used)
//   frame_error  out  one-cycle pulse: bad length or inter-byte timeout
//   busy         out  high whenever the block is not idle
// -----------------------------------------------------------------------------
module host_rx_packet_assembler #(
  parameter int DATA_WIDTH     = 1024,
  parameter int MAX_BYTES      = 128,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int TIMEOUT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic [DATA_WIDTH-1:0] packet_data,
  output logic                  send_packet,
  input  logic                  done,
  output logic                  frame_error,
  output logic                  busy
);

  localparam int IDX_W = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RECV      = 2'd1,
    ST_SEND      = 2'd2,
    ST_WAIT_DONE = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_next_state;
  logic [7:0]              r_len;
  logic [7:0]              r_count;
  logic [TIMEOUT_WIDTH-1:0] r_timeout;
  logic                    r_done_q;
  logic                    r_rx_ready;
  logic                    r_send_packet;
  logic                    r_frame_error;
  logic                    r_busy;
  logic [DATA_WIDTH-1:0]   r_packet_data;

  logic                    w_accept;
  logic                    w_done_rise;
  logic                    w_len_bad;
  logic                    w_last_byte;
  logic [TIMEOUT_WIDTH-1:0] w_timeout_inc;
  logic [IDX_W-1:0]        w_bit_idx;
  logic                    w_len_load;
  logic                    w_byte_store;
  logic                    w_timeout_step;
  logic                    w_data_clr;
  logic                    w_err;

  // rx_ready is registered, so acceptance is judged against the value the
  // host actually sees this cycle.
  assign w_accept      = rx_valid && r_rx_ready;
  assign w_done_rise   = done && !r_done_q;
  assign w_len_bad     = (rx_byte == 8'd0) || (rx_byte > 8'(MAX_BYTES));
  assign w_last_byte   = ((r_count + 8'd1) == r_len);
  assign w_timeout_inc = r_timeout + {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};
  assign w_bit_idx     = IDX_W'({r_count, 3'b000});

  // Next-state and datapath control decode.
  always_comb begin
    w_next_state   = r_state;
    w_len_load     = 1'b0;
    w_byte_store   = 1'b0;
    w_timeout_step = 1'b0;
    w_data_clr     = 1'b0;
    w_err          = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (w_len_bad) begin
            w_err = 1'b1;
          end else begin
            w_len_load   = 1'b1;
            w_data_clr   = 1'b1;
            w_next_state = ST_RECV;
          end
        end else begin
          w_next_state = ST_IDLE;
        end
      end
      ST_RECV: begin
        if (w_accept) begin
          w_byte_store = 1'b1;
          if (w_last_byte) begin
            w_next_state = ST_SEND;
          end else begin
            w_next_state = ST_RECV;
          end
        end else if (w_timeout_inc == TIMEOUT_WIDTH'(TIMEOUT_CYCLES)) begin
          // Host went quiet mid-frame: drop the partial payload.
          w_err        = 1'b1;
          w_data_clr   = 1'b1;
          w_next_state = ST_IDLE;
        end else begin
          w_timeout_step = 1'b1;
        end
      end
      ST_SEND: begin
        w_next_state = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        // Only a fresh edge completes; a level already high on entry has
        // done_q set and is ignored.
        if (w_done_rise) begin
          w_next_state = ST_IDLE;
        end else begin
          w_next_state = ST_WAIT_DONE;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // State, control counters and registered status outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= ST_IDLE;
      r_len         <= 8'd0;
      r_count       <= 8'd0;
      r_timeout     <= '0;
      r_done_q      <= 1'b0;
      r_rx_ready    <= 1'b0;
      r_send_packet <= 1'b0;
      r_frame_error <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_next_state;
      r_done_q      <= done;
      // Status outputs are derived from the state being entered so they line
      // up with that state's cycle.
      r_rx_ready    <= (w_next_state == ST_IDLE) || (w_next_state == ST_RECV);
      r_send_packet <= (w_next_state == ST_SEND);
      r_busy        <= (w_next_state != ST_IDLE);
      r_frame_error <= w_err;
      if (w_len_load) begin
        r_len     <= rx_byte;
        r_count   <= 8'd0;
        r_timeout <= '0;
      end else if (w_byte_store) begin
        r_count   <= r_count + 8'd1;
        r_timeout <= '0;
      end else if (w_timeout_step) begin
        r_timeout <= w_timeout_inc;
      end else begin
        r_timeout <= r_timeout;
      end
    end
  end

  // Payload assembly register; cleared at frame start and on timeout.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_packet_data <= '0;
    end else if (w_data_clr) begin
      r_packet_data <= '0;
    end else if (w_byte_store) begin
      r_packet_data[w_bit_idx +: 8] <= rx_byte;
    end else begin
      r_packet_data <= r_packet_data;
    end
  end

  assign rx_ready    = r_rx_ready;
  assign packet_data = r_packet_data;
  assign send_packet = r_send_packet;
  assign frame_error = r_frame_error;
  assign busy        = r_busy;

endmodule
